// File: rtl/data_tag_multi.sv
// data_tag_multi
//   Multi-window receive data tagger. Tracks NUM_WIN independent receive
//   windows, tags the first decimated sample of each window (or every sample
//   in gate mode), counts samples per window, pulses on window close and
//   keeps a wrapping per-window pulse (window) number.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   strobe       decimated sample strobe, one-cycle pulse
//   enable       per-window gate (level, synchronous to clk)
//   mode         per-window tag mode: 0 = first sample only, 1 = every sample
//   strobe_out   strobe delayed one cycle, aligned with tag
//   tag          per-window tag, valid only while strobe_out = 1
//   win_done     per-window one-cycle pulse after the window closes
//   sample_count window i at [i*CNT_W +: CNT_W], saturating strobe count
//   pulse_num    window i at [i*PULSE_W +: PULSE_W], windows opened since reset
module data_tag_multi #(
  parameter int unsigned NUM_WIN = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned PULSE_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       strobe,
  input  logic [NUM_WIN-1:0]         enable,
  input  logic [NUM_WIN-1:0]         mode,
  output logic                       strobe_out,
  output logic [NUM_WIN-1:0]         tag,
  output logic [NUM_WIN-1:0]         win_done,
  output logic [NUM_WIN*CNT_W-1:0]   sample_count,
  output logic [NUM_WIN*PULSE_W-1:0] pulse_num
);

  logic [NUM_WIN-1:0] r_enable_d;
  logic [NUM_WIN-1:0] r_pending;
  logic [NUM_WIN-1:0] r_mode_l;
  logic [NUM_WIN-1:0] r_tag;
  logic [NUM_WIN-1:0] r_win_done;
  logic               r_strobe_out;
  logic [CNT_W-1:0]   r_cnt   [NUM_WIN];
  logic [PULSE_W-1:0] r_pulse [NUM_WIN];

  logic [NUM_WIN-1:0] w_rise;
  logic [NUM_WIN-1:0] w_fall;
  logic [NUM_WIN-1:0] w_sample;
  logic [NUM_WIN-1:0] w_mode_eff;
  logic [NUM_WIN-1:0] w_tag_next;

  always_comb begin
    w_rise     = enable & ~r_enable_d;
    w_fall     = ~enable & r_enable_d;
    w_sample   = enable & {NUM_WIN{strobe}};
    // Mode is only sampled at window open; on the opening cycle itself the
    // latch has not been written yet, so use the live input.
    w_mode_eff = (w_rise & mode) | (~w_rise & r_mode_l);
    w_tag_next = w_sample & (r_pending | w_rise | w_mode_eff);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_enable_d   <= '0;
      r_pending    <= '0;
      r_mode_l     <= '0;
      r_tag        <= '0;
      r_win_done   <= '0;
      r_strobe_out <= 1'b0;
      for (int unsigned i = 0; i < NUM_WIN; i++) begin
        r_cnt[i]   <= '0;
        r_pulse[i] <= '0;
      end
    end else begin
      r_enable_d   <= enable;
      r_strobe_out <= strobe;
      r_tag        <= w_tag_next;
      r_win_done   <= w_fall;
      // Pending survives only while the window stays open with no strobe;
      // a strobe consumes it and a close (enable low) discards it.
      r_pending    <= enable & ~{NUM_WIN{strobe}} & (r_pending | w_rise);
      for (int unsigned i = 0; i < NUM_WIN; i++) begin
        if (w_rise[i]) begin
          r_mode_l[i] <= mode[i];
          r_pulse[i]  <= r_pulse[i] + PULSE_W'(1);
          // A strobe on the opening cycle is the window's first sample.
          r_cnt[i]    <= CNT_W'(strobe);
        end else if (w_sample[i] && (r_cnt[i] != '1)) begin
          r_cnt[i]    <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    sample_count = '0;
    pulse_num    = '0;
    for (int unsigned i = 0; i < NUM_WIN; i++) begin
      sample_count[i*CNT_W +: CNT_W]     = r_cnt[i];
      pulse_num[i*PULSE_W +: PULSE_W]    = r_pulse[i];
    end
  end

  assign strobe_out = r_strobe_out;
  assign tag        = r_tag;
  assign win_done   = r_win_done;

endmodule

// File: tb/tb_data_tag_multi.sv
module tb_data_tag_multi;

  logic        clk;
  logic        reset;
  logic        strobe;
  logic [3:0]  enable;
  logic [3:0]  mode;
  logic        strobe_out;
  logic [3:0]  tag;
  logic [3:0]  win_done;
  logic [63:0] sample_count;
  logic [31:0] pulse_num;

  // Small instance for saturate / wrap boundaries
  logic        strobe2;
  logic [3:0]  enable2;
  logic [3:0]  mode2;
  logic        strobe_out2;
  logic [3:0]  tag2;
  logic [3:0]  win_done2;
  logic [15:0] sample_count2;
  logic [7:0]  pulse_num2;

  int n_checks;
  int n_pass;

  data_tag_multi #(.NUM_WIN(4), .CNT_W(16), .PULSE_W(8)) dut (
    .clk(clk), .reset(reset), .strobe(strobe), .enable(enable), .mode(mode),
    .strobe_out(strobe_out), .tag(tag), .win_done(win_done),
    .sample_count(sample_count), .pulse_num(pulse_num)
  );

  data_tag_multi #(.NUM_WIN(4), .CNT_W(4), .PULSE_W(2)) dut2 (
    .clk(clk), .reset(reset), .strobe(strobe2), .enable(enable2), .mode(mode2),
    .strobe_out(strobe_out2), .tag(tag2), .win_done(win_done2),
    .sample_count(sample_count2), .pulse_num(pulse_num2)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [15:0] cnt(input int i);
    return sample_count[i*16 +: 16];
  endfunction

  function automatic logic [7:0] pnum(input int i);
    return pulse_num[i*8 +: 8];
  endfunction

  // Inputs applied after this returns are captured at the next edge;
  // outputs read after it reflect the previous inputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; strobe = 1'b1; enable = '1; mode = '1;
    strobe2 = 1'b0; enable2 = '0; mode2 = '0;
    tick();
    tick();
    n_checks++;
    if ({strobe_out, tag, win_done, sample_count, pulse_num} !== '0)
      $display("FAIL reset_outputs: got so=%b tag=%b wd=%b cnt=%h pn=%h, want all 0",
               strobe_out, tag, win_done, sample_count, pulse_num);
    else n_pass++;
    reset = 1'b0; strobe = 1'b0; enable = '0; mode = '0;
    tick();
    n_checks++;
    if ({strobe_out, tag, win_done} !== '0)
      $display("FAIL reset_idle: got so=%b tag=%b wd=%b, want 0", strobe_out, tag, win_done);
    else n_pass++;
  endtask

  task automatic test_first_sample();
    int ntag = 0, nwd = 0, first_c = -1;
    for (int c = 0; c < 260; c++) begin
      enable[0] = (c >= 5 && c < 255);
      strobe    = (c % 64 == 63);
      tick();
      if (tag[0] && strobe_out) begin
        ntag++;
        if (first_c < 0) first_c = c;
      end
      if (win_done[0]) nwd++;
      n_checks++;
      if ((tag & ~{4{strobe_out}}) !== 4'b0)
        $display("FAIL tag_without_strobe c=%0d: tag=%b strobe_out=%b", c, tag, strobe_out);
      else n_pass++;
    end
    strobe = 1'b0;
    n_checks++;
    if (ntag !== 1) $display("FAIL first_tag_count: got %0d want 1", ntag); else n_pass++;
    n_checks++;
    if (first_c !== 63) $display("FAIL first_tag_pos: got %0d want 63", first_c); else n_pass++;
    n_checks++;
    if (cnt(0) !== 16'd3) $display("FAIL first_count: got %0d want 3", cnt(0)); else n_pass++;
    n_checks++;
    if (nwd !== 1) $display("FAIL first_win_done: got %0d want 1", nwd); else n_pass++;
    n_checks++;
    if (pnum(0) !== 8'd1) $display("FAIL first_pulse: got %0d want 1", pnum(0)); else n_pass++;
  endtask

  task automatic test_gate_mode();
    int ntag = 0, ntag0 = 0, nwd = 0;
    for (int c = 0; c < 330; c++) begin
      enable[1] = (c >= 2 && c < 322);
      mode[1]   = (c < 100);
      strobe    = (c % 64 == 63);
      tick();
      if (tag[1] && strobe_out) ntag++;
      if (tag[0]) ntag0++;
      if (win_done[1]) nwd++;
    end
    strobe = 1'b0; mode = '0;
    n_checks++;
    if (ntag !== 5) $display("FAIL gate_tag_count: got %0d want 5", ntag); else n_pass++;
    n_checks++;
    if (cnt(1) !== 16'd5) $display("FAIL gate_count: got %0d want 5", cnt(1)); else n_pass++;
    n_checks++;
    if (nwd !== 1) $display("FAIL gate_win_done: got %0d want 1", nwd); else n_pass++;
    n_checks++;
    if (ntag0 !== 0) $display("FAIL closed_win_tag: got %0d want 0", ntag0); else n_pass++;
    n_checks++;
    if (cnt(0) !== 16'd3) $display("FAIL closed_win_hold: got %0d want 3", cnt(0)); else n_pass++;
  endtask

  task automatic test_rise_strobe();
    enable[2] = 1'b1; strobe = 1'b1; mode[2] = 1'b0;
    tick();
    n_checks++;
    if ({strobe_out, tag[2], cnt(2), pnum(2)} !== {1'b1, 1'b1, 16'd1, 8'd1})
      $display("FAIL rise_strobe: got so=%b tag=%b cnt=%0d pn=%0d want 1 1 1 1",
               strobe_out, tag[2], cnt(2), pnum(2));
    else n_pass++;
    strobe = 1'b0;
    tick();
    strobe = 1'b1;
    tick();
    n_checks++;
    if ({strobe_out, tag[2], cnt(2)} !== {1'b1, 1'b0, 16'd2})
      $display("FAIL rise_second: got so=%b tag=%b cnt=%0d want 1 0 2",
               strobe_out, tag[2], cnt(2));
    else n_pass++;
    strobe = 1'b0; enable[2] = 1'b0;
    tick();
    n_checks++;
    if (win_done !== 4'b0100) $display("FAIL rise_win_done: got %b want 0100", win_done); else n_pass++;
    tick();
    n_checks++;
    if (win_done !== 4'b0000) $display("FAIL win_done_pulse: got %b want 0000", win_done); else n_pass++;
  endtask

  task automatic test_no_strobe();
    for (int w = 1; w <= 2; w++) begin
      enable[3] = 1'b1;
      for (int c = 0; c < 10; c++) begin
        tick();
        n_checks++;
        if (tag[3] !== 1'b0) $display("FAIL nostrobe_tag: got %b want 0", tag[3]); else n_pass++;
      end
      // strobe on the fall cycle must not count
      enable[3] = 1'b0; strobe = 1'b1;
      tick();
      strobe = 1'b0;
      n_checks++;
      if ({strobe_out, tag[3], win_done[3], cnt(3), pnum(3)} !== {1'b1, 1'b0, 1'b1, 16'd0, 8'(w)})
        $display("FAIL nostrobe_close w=%0d: got so=%b tag=%b wd=%b cnt=%0d pn=%0d want 1 0 1 0 %0d",
                 w, strobe_out, tag[3], win_done[3], cnt(3), pnum(3), w);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_saturate_wrap();
    logic [1:0] exp_pn [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    enable2[0] = 1'b1;
    strobe2 = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    n_checks++;
    if (sample_count2[3:0] !== 4'd15) $display("FAIL saturate: got %0d want 15", sample_count2[3:0]); else n_pass++;
    n_checks++;
    if (pulse_num2[1:0] !== 2'd1) $display("FAIL wrap_pn0: got %0d want 1", pulse_num2[1:0]); else n_pass++;
    strobe2 = 1'b0; enable2[0] = 1'b0;
    tick();
    n_checks++;
    if (sample_count2[3:0] !== 4'd15) $display("FAIL saturate_hold: got %0d want 15", sample_count2[3:0]); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      enable2[0] = 1'b1;
      tick();
      n_checks++;
      if (pulse_num2[1:0] !== exp_pn[k])
        $display("FAIL wrap_pn k=%0d: got %0d want %0d", k, pulse_num2[1:0], exp_pn[k]);
      else n_pass++;
      enable2[0] = 1'b0;
      tick();
      n_checks++;
      if (win_done2 !== 4'b0001) $display("FAIL min_window k=%0d: got %b want 0001", k, win_done2); else n_pass++;
    end
    tick();
  endtask

  task automatic test_reset_mid_window();
    enable[0] = 1'b1;
    tick();
    n_checks++;
    if (pnum(0) !== 8'd2) $display("FAIL pre_reset_pn: got %0d want 2", pnum(0)); else n_pass++;
    tick();
    reset = 1'b1; strobe = 1'b1;
    tick();
    n_checks++;
    if ({strobe_out, tag, win_done, sample_count, pulse_num} !== '0)
      $display("FAIL midreset_outputs: got so=%b tag=%b wd=%b cnt=%h pn=%h, want all 0",
               strobe_out, tag, win_done, sample_count, pulse_num);
    else n_pass++;
    reset = 1'b0; strobe = 1'b0;
    tick();
    n_checks++;
    if ({win_done[0], pnum(0)} !== {1'b0, 8'd1})
      $display("FAIL midreset_rise: got wd=%b pn=%0d want 0 1", win_done[0], pnum(0));
    else n_pass++;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    n_checks++;
    if ({strobe_out, tag[0], cnt(0)} !== {1'b1, 1'b1, 16'd1})
      $display("FAIL midreset_tag: got so=%b tag=%b cnt=%0d want 1 1 1", strobe_out, tag[0], cnt(0));
    else n_pass++;
    tick();
    n_checks++;
    if (win_done !== 4'b0) $display("FAIL midreset_no_done: got %b want 0000", win_done); else n_pass++;
    enable[0] = 1'b0;
    tick();
    n_checks++;
    if (win_done !== 4'b0001) $display("FAIL midreset_close: got %b want 0001", win_done); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_first_sample();
    test_gate_mode();
    test_rise_strobe();
    test_no_strobe();
    test_saturate_wrap();
    test_reset_mid_window();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
